// File: rtl/pipe_seq_ctrl_if.sv
// Valid/ready handshake bundle for both ends of the controlled pipeline.
// The master side drives in_valid/out_ready; the controller is the slave.
interface pipe_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport master (
        output in_valid,
        input  in_ready,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_valid,
        output in_ready,
        output out_valid,
        input  out_ready
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Flow controller for an N-deep register pipeline: valid tracking, stage enables,
// flush/drain sequencing. Optional macro PIPE_CTRL_BUBBLE_EN enables bubble collapsing.
module pipe_seq_ctrl #(
    parameter int N     = 4,
    parameter int OCC_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_seq_ctrl_if.slave   hs,
    input  logic             flush,
    input  logic             drain,
    output logic [N-1:0]     stage_en,
    output logic [N-1:0]     stage_vld,
    output logic [OCC_W-1:0] occupancy,
    output logic             busy,
    output logic             drain_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [N-1:0]       vld_reg;
    logic [N-1:0]       vld_next;
    logic [N-1:0]       en;
    logic [OCC_W-1:0]   occ_reg;
    logic [OCC_W-1:0]   occ_next;
    logic               accept;
    logic               in_xfer;
    logic               out_xfer;

`ifdef PIPE_CTRL_BUBBLE_EN
    // A stage may load when it is empty or when its successor is moving on.
    assign en[N-1] = !vld_reg[N-1] | hs.out_ready;
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_bubble_en
        assign en[gi] = !vld_reg[gi] | en[gi+1];
    end
`else
    logic adv;
    assign adv = !vld_reg[N-1] | hs.out_ready;
    assign en  = {N{adv}};
`endif

    // Enables are forced low while in reset so the datapath never loads then.
    assign stage_en     = rst_n ? en : '0;
    assign hs.in_ready  = en[0] & accept;
    assign hs.out_valid = vld_reg[N-1];
    assign stage_vld    = vld_reg;
    assign occupancy    = occ_reg;

    assign in_xfer  = hs.in_valid & hs.in_ready;
    assign out_xfer = hs.out_valid & hs.out_ready;

    for (genvar gi = 0; gi < N; gi++) begin : g_vld
        if (gi == 0) begin : g_first
            assign vld_next[gi] = flush ? 1'b0 : (en[gi] ? in_xfer : vld_reg[gi]);
        end else begin : g_rest
            assign vld_next[gi] = flush ? 1'b0 : (en[gi] ? vld_reg[gi-1] : vld_reg[gi]);
        end
    end

    assign occ_next = flush ? '0 : (occ_reg + OCC_W'(in_xfer) - OCC_W'(out_xfer));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
            occ_reg <= '0;
        end else begin
            vld_reg <= vld_next;
            occ_reg <= occ_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Drain outranks both flush and the empty-pipe return to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (drain) begin
                    state_next = DONE;
                end else if (flush) begin
                    state_next = IDLE;
                end else if (in_xfer) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (drain) begin
                    state_next = flush ? DONE : DRAIN;
                end else if (flush || (occ_next == '0)) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                if (flush || (occ_next == '0)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A drain request also blocks the word offered in the same cycle.
    always_comb begin
        accept     = 1'b0;
        busy       = 1'b0;
        drain_done = 1'b0;
        case (state_reg)
            IDLE: begin
                accept = rst_n & !flush & !drain;
            end
            RUN: begin
                accept = rst_n & !flush & !drain;
                busy   = 1'b1;
            end
            DRAIN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy       = 1'b1;
                drain_done = 1'b1;
            end
            default: begin
                accept = 1'b0;
            end
        endcase
    end

endmodule
